// File: rtl/mfp_7seg_scanner_if.sv
// Bundle between the GPIO 7-segment register and the display scanner.
// The master side supplies the value and decimal points.
// The slave side (the scanner) drives the segment, dp and anode lines.
interface mfp_7seg_scanner_if #(
    parameter int DIGITS = 8
) ();
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [6:0]          seg;
    logic                seg_dp;
    logic [DIGITS-1:0]   an;
    logic                frame_start;

    modport master (
        output value,
        output dp,
        input  seg,
        input  seg_dp,
        input  an,
        input  frame_start
    );

    modport slave (
        input  value,
        input  dp,
        output seg,
        output seg_dp,
        output an,
        output frame_start
    );
endinterface

// File: rtl/mfp_7seg_scanner.sv
// Time-multiplexed hex display scanner.
// Each digit is driven for REFRESH_DIV cycles, followed by an optional
// BLANK_CYCLES all-off gap. value/dp are snapshotted on entry to digit 0,
// so a mid-frame write never tears the display. Every output is a flop.
module mfp_7seg_scanner #(
    parameter int DIGITS         = 8,
    parameter int REFRESH_DIV    = 1024,
    parameter int BLANK_CYCLES   = 16,
    parameter int LZ_BLANK       = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input logic                clk,
    input logic                rst,
    mfp_7seg_scanner_if.slave  bus
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] DRIVE_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

    // XOR masks applied at the flop inputs; internal logic is active-high.
    // The masks also equal the "all off" level of each output.
    localparam logic [6:0]        SEG_POL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              DP_POL  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [DIGITS-1:0] AN_POL  = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // S_START: reset just released, digit 0 is about to be entered.
    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [DW-1:0]       digit;
    logic [4*DIGITS-1:0] snap_value;
    logic [DIGITS-1:0]   snap_dp;
    logic [6:0]          seg_r;
    logic                seg_dp_r;
    logic [DIGITS-1:0]   an_r;
    logic                frame_start_r;

    logic [DW-1:0]       next_digit;
    logic                wrap;
    logic [7:0]          pat_next;
    logic [7:0]          pat_first;

    // Hex to active-high gfedcba segments.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Active-high {dp, seg} for digit idx of a frame, with leading-zero
    // blanking: a digit above 0 goes dark (dp included) when it and every
    // more significant nibble are zero.
    function automatic logic [7:0] digit_pattern(
        input logic [4*DIGITS-1:0] val,
        input logic [DIGITS-1:0]   pts,
        input logic [DW-1:0]       idx
    );
        logic nonzero;
        logic blank;
        nonzero = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(idx)) && (val[4*i +: 4] != 4'h0)) begin
                nonzero = 1'b1;
            end
        end
        blank = (LZ_BLANK != 0) && (idx != '0) && !nonzero;
        if (blank) begin
            return 8'h00;
        end else begin
            return {pts[idx], hex_decode(val[4*idx +: 4])};
        end
    endfunction

    // Active-high one-hot anode select.
    function automatic logic [DIGITS-1:0] onehot(input logic [DW-1:0] idx);
        logic [DIGITS-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    // Work out the next digit and its pattern. Entering digit 0 decodes
    // the live inputs, because the snapshot loads on that same edge.
    always_comb begin
        wrap       = (digit == DIGIT_LAST);
        next_digit = wrap ? '0 : (digit + DW'(1));
        pat_first  = digit_pattern(bus.value, bus.dp, '0);
        if (wrap) begin
            pat_next = pat_first;
        end else begin
            pat_next = digit_pattern(snap_value, snap_dp, next_digit);
        end
    end

    // Scan FSM: dwell counter, digit index, snapshot and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_START;
            cnt           <= '0;
            digit         <= '0;
            snap_value    <= '0;
            snap_dp       <= '0;
            seg_r         <= SEG_POL;
            seg_dp_r      <= DP_POL;
            an_r          <= AN_POL;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= 1'b0;
            case (state)
                S_START: begin
                    state         <= S_DRIVE;
                    cnt           <= '0;
                    digit         <= '0;
                    snap_value    <= bus.value;
                    snap_dp       <= bus.dp;
                    seg_r         <= pat_first[6:0] ^ SEG_POL;
                    seg_dp_r      <= pat_first[7] ^ DP_POL;
                    an_r          <= onehot('0) ^ AN_POL;
                    frame_start_r <= 1'b1;
                end
                S_DRIVE: begin
                    if (cnt != DRIVE_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else if (BLANK_CYCLES > 0) begin
                        state    <= S_GAP;
                        cnt      <= '0;
                        seg_r    <= SEG_POL;
                        seg_dp_r <= DP_POL;
                        an_r     <= AN_POL;
                    end else begin
                        cnt      <= '0;
                        digit    <= next_digit;
                        seg_r    <= pat_next[6:0] ^ SEG_POL;
                        seg_dp_r <= pat_next[7] ^ DP_POL;
                        an_r     <= onehot(next_digit) ^ AN_POL;
                        if (wrap) begin
                            snap_value    <= bus.value;
                            snap_dp       <= bus.dp;
                            frame_start_r <= 1'b1;
                        end else begin
                            frame_start_r <= 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt != GAP_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        state    <= S_DRIVE;
                        cnt      <= '0;
                        digit    <= next_digit;
                        seg_r    <= pat_next[6:0] ^ SEG_POL;
                        seg_dp_r <= pat_next[7] ^ DP_POL;
                        an_r     <= onehot(next_digit) ^ AN_POL;
                        if (wrap) begin
                            snap_value    <= bus.value;
                            snap_dp       <= bus.dp;
                            frame_start_r <= 1'b1;
                        end else begin
                            frame_start_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= S_START;
                    cnt      <= '0;
                    digit    <= '0;
                    seg_r    <= SEG_POL;
                    seg_dp_r <= DP_POL;
                    an_r     <= AN_POL;
                end
            endcase
        end
    end

    assign bus.seg         = seg_r;
    assign bus.seg_dp      = seg_dp_r;
    assign bus.an          = an_r;
    assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_mfp_7seg_scanner.sv
// Bench for mfp_7seg_scanner: three instances with different dwell, gap,
// blanking and polarity settings are run together. Every cycle, each
// instance is compared against a reference model. The model computes the
// expected outputs arithmetically from the number of cycles since reset
// release and the value it latched at each frame start.
module tb_mfp_7seg_scanner;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Per-instance configuration: A = gap + active-low,
    // B = leading-zero blanking + active-high, C = no gap, one cycle per digit.
    int cfg_r  [3] = '{4, 4, 1};
    int cfg_b  [3] = '{2, 2, 0};
    int cfg_lz [3] = '{0, 1, 0};
    int cfg_lo [3] = '{1, 0, 1};

    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [31:0] val     [3];
    logic [7:0]  dpv     [3];
    bit          running [3];
    int          t       [3];
    logic [31:0] snap_v  [3];
    logic [7:0]  snap_d  [3];

    int checks = 0;
    int errors = 0;

    mfp_7seg_scanner_if #(.DIGITS(8)) if_a ();
    mfp_7seg_scanner_if #(.DIGITS(8)) if_b ();
    mfp_7seg_scanner_if #(.DIGITS(8)) if_c ();

    assign if_a.value = val[0];
    assign if_a.dp    = dpv[0];
    assign if_b.value = val[1];
    assign if_b.dp    = dpv[1];
    assign if_c.value = val[2];
    assign if_c.dp    = dpv[2];

    mfp_7seg_scanner #(.DIGITS(8), .REFRESH_DIV(4), .BLANK_CYCLES(2), .LZ_BLANK(0),
                       .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    mfp_7seg_scanner #(.DIGITS(8), .REFRESH_DIV(4), .BLANK_CYCLES(2), .LZ_BLANK(1),
                       .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0))
        dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    mfp_7seg_scanner #(.DIGITS(8), .REFRESH_DIV(1), .BLANK_CYCLES(0), .LZ_BLANK(0),
                       .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1))
        dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    // Expected {an, seg, seg_dp, frame_start} for instance id in the current cycle.
    function automatic logic [16:0] model_out(int id);
        logic [7:0] an;
        logic [6:0] sg;
        logic       p;
        logic       fs;
        int         per;
        int         k;
        int         s;
        an = 8'h00;
        sg = 7'h00;
        p  = 1'b0;
        fs = 1'b0;
        if (running[id]) begin
            per = cfg_r[id] + cfg_b[id];
            k   = (t[id] / per) % 8;
            s   = t[id] % per;
            fs  = ((t[id] % (8 * per)) == 0);
            if (s < cfg_r[id]) begin
                an = 8'h01 << k;
                sg = hex_tbl[snap_v[id][4*k +: 4]];
                p  = snap_d[id][k];
                if ((cfg_lz[id] != 0) && (k > 0) && ((snap_v[id] >> (4 * k)) == 32'h0)) begin
                    sg = 7'h00;
                    p  = 1'b0;
                end
            end
        end
        if (cfg_lo[id] != 0) begin
            an = ~an;
            sg = ~sg;
            p  = ~p;
        end
        return {an, sg, p, fs};
    endfunction

    // Advance one clock: update the model from inputs at the edge, then
    // compare all instances 1 time unit later.
    task automatic tick();
        logic [16:0] obs;
        logic [16:0] exp;
        @(posedge clk);
        for (int id = 0; id < 3; id++) begin
            if (rst) begin
                running[id] = 1'b0;
                t[id]       = 0;
            end else if (!running[id]) begin
                running[id] = 1'b1;
                t[id]       = 0;
            end else begin
                t[id] = t[id] + 1;
            end
            if (running[id] && ((t[id] % (8 * (cfg_r[id] + cfg_b[id]))) == 0)) begin
                snap_v[id] = val[id];
                snap_d[id] = dpv[id];
            end
        end
        #1;
        for (int id = 0; id < 3; id++) begin
            case (id)
                0:       obs = {if_a.an, if_a.seg, if_a.seg_dp, if_a.frame_start};
                1:       obs = {if_b.an, if_b.seg, if_b.seg_dp, if_b.frame_start};
                default: obs = {if_c.an, if_c.seg, if_c.seg_dp, if_c.frame_start};
            endcase
            exp    = model_out(id);
            checks = checks + 1;
            assert (obs === exp) else begin
                errors = errors + 1;
                $error("FAIL dut%0d t=%0d {an,seg,dp,fs} observed=%h expected=%h",
                       id, t[id], obs, exp);
            end
        end
    endtask

    initial begin
        // Reset held three cycles with all-ones input.
        rst = 1'b1;
        for (int id = 0; id < 3; id++) begin
            val[id]     = 32'hFFFF_FFFF;
            dpv[id]     = 8'hFF;
            running[id] = 1'b0;
            t[id]       = 0;
            snap_v[id]  = 32'h0;
            snap_d[id]  = 8'h0;
        end
        repeat (3) tick();

        // Scan order and leading-zero patterns.
        rst    = 1'b0;
        val[0] = 32'h0123_ABCD;
        dpv[0] = 8'h00;
        val[1] = 32'h0000_0050;
        dpv[1] = 8'h80;
        val[2] = 32'h89AB_CDEF;
        dpv[2] = 8'h5A;
        repeat (60) tick();

        // No tearing: write a new value while A drives digit 3.
        for (int i = 0; (i < 100) && ((t[0] % 48) != 20); i++) tick();
        val[0] = 32'h89AB_CDEF;
        dpv[0] = 8'h21;
        val[2] = 32'h1357_9BDF;
        repeat (70) tick();

        // All-zero value on the blanking instance: digit 0 still shows 0.
        val[1] = 32'h0000_0000;
        dpv[1] = 8'hFF;
        repeat (70) tick();

        // Randomized writes at arbitrary points in the frame.
        for (int i = 0; i < 400; i++) begin
            for (int id = 0; id < 3; id++) begin
                if ($urandom_range(0, 11) == 0) begin
                    val[id] = $urandom >> $urandom_range(0, 31);
                    dpv[id] = 8'($urandom);
                end
            end
            tick();
        end

        // One-cycle reset while A drives digit 5, then a fresh snapshot.
        for (int i = 0; (i < 100) && ((t[0] % 48) != 31); i++) tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        val[0] = 32'hFEDC_BA98;
        val[1] = 32'h0000_0A00;
        val[2] = 32'h7654_3210;
        repeat (120) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
